// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared opcodes, mode enum and address constants for the HD44780 receiver
package lcd_pkg;

  typedef enum logic [1:0] {INIT8, HI, LO} mode_e;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_DISP  = 8'h08;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_DDRAM = 8'h80;

  localparam logic [6:0] LINE2_BASE = 7'h40;

  // Opcode matches when its single set bit is the highest set bit of b.
  function automatic logic is_cmd(input logic [7:0] b, input logic [7:0] op);
    return (b & ~(op - 8'd1)) == op;
  endfunction

endpackage

// File: rtl/lcd_nibble_rx.sv
// rtl/lcd_nibble_rx.sv - E falling-edge capture, init handshake and nibble pairing
module lcd_nibble_rx
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_w,
  input  logic       lcd_rs,
  input  logic [3:0] data,
  input  logic       drop_busy,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_rs,
  output logic       err
);

  logic       e_q, e_d;
  logic       w_q, w_d;
  logic       rs_q, rs_d;
  logic [3:0] d_q, d_d;
  logic [3:0] hi_q, hi_d;
  mode_e      mode_q, mode_d;

  always_comb begin
    e_d        = lcd_e;
    w_d        = lcd_w;
    rs_d       = lcd_rs;
    d_d        = data;
    hi_d       = hi_q;
    mode_d     = mode_q;
    byte_valid = 1'b0;
    byte_data  = {hi_q, d_q};
    byte_rs    = rs_q;
    err        = 1'b0;
    if (e_q && !lcd_e) begin
      if (w_q || drop_busy) begin
        err = 1'b1;
      end else begin
        case (mode_q)
          INIT8: begin
            if (d_q == 4'h2) mode_d = HI;
            else if (d_q != 4'h3) err = 1'b1;
          end
          HI: begin
            hi_d   = d_q;
            mode_d = LO;
          end
          LO: begin
            byte_valid = 1'b1;
            // Function set with DL=1 drops the bus back to 8-bit handshake.
            if (!rs_q && is_cmd(byte_data, CMD_FUNC) && byte_data[4]) mode_d = INIT8;
            else mode_d = HI;
          end
          default: mode_d = INIT8;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q    <= 1'b0;
      w_q    <= 1'b0;
      rs_q   <= 1'b0;
      d_q    <= 4'h0;
      hi_q   <= 4'h0;
      mode_q <= INIT8;
    end else begin
      e_q    <= e_d;
      w_q    <= w_d;
      rs_q   <= rs_d;
      d_q    <= d_d;
      hi_q   <= hi_d;
      mode_q <= mode_d;
    end
  end

endmodule

// File: rtl/lcd_hd44780_rx.sv
// rtl/lcd_hd44780_rx.sv - HD44780 4-bit bus receiver with command decode and 2-line buffer
module lcd_hd44780_rx
  import lcd_pkg::*;
#(
  parameter int         COLS  = 16,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lcd_e,
  input  logic              lcd_w,
  input  logic              lcd_rs,
  input  logic [3:0]        data,
  output logic [8*COLS-1:0] first_line,
  output logic [8*COLS-1:0] second_line,
  output logic              display_on,
  output logic [6:0]        cursor,
  output logic              busy,
  output logic              byte_valid,
  output logic [7:0]        byte_out,
  output logic              byte_rs,
  output logic              err
);

  localparam int SW = $clog2(2 * COLS);
  localparam logic [SW-1:0] SWEEP_LAST = SW'(2 * COLS - 1);

  logic [8*COLS-1:0] line1_q, line1_d, line2_q, line2_d;
  logic [6:0]        cursor_q, cursor_d;
  logic              disp_q, disp_d, inc_q, inc_d, busy_q, busy_d;
  logic [SW-1:0]     sweep_q, sweep_d, sweep_col;
  logic              sweep_line;
  logic              bv_q, bv_d, err_q, err_d, brs_q, brs_d;
  logic [7:0]        bo_q, bo_d;
  logic              rx_valid, rx_rs, rx_err, drop_busy;
  logic [7:0]        rx_byte;
  logic [3:0]        col_n;
  logic              line_n;

  // The final sweep cycle still accepts an edge so a byte can land as busy drops.
  assign drop_busy  = busy_q && (sweep_q != SWEEP_LAST);
  assign sweep_line = sweep_q >= SW'(COLS);
  assign sweep_col  = sweep_line ? sweep_q - SW'(COLS) : sweep_q;

  lcd_nibble_rx u_nibble_rx (
    .clk        (clk),
    .rst        (rst),
    .lcd_e      (lcd_e),
    .lcd_w      (lcd_w),
    .lcd_rs     (lcd_rs),
    .data       (data),
    .drop_busy  (drop_busy),
    .byte_valid (rx_valid),
    .byte_data  (rx_byte),
    .byte_rs    (rx_rs),
    .err        (rx_err)
  );

  always_comb begin
    line1_d  = line1_q;
    line2_d  = line2_q;
    cursor_d = cursor_q;
    disp_d   = disp_q;
    inc_d    = inc_q;
    busy_d   = busy_q;
    sweep_d  = sweep_q;
    bv_d     = 1'b0;
    err_d    = rx_err;
    bo_d     = bo_q;
    brs_d    = brs_q;
    col_n    = cursor_q[3:0];
    line_n   = cursor_q[6];

    if (busy_q) begin
      if (sweep_line) line2_d[8*(COLS-1-int'(sweep_col)) +: 8] = BLANK;
      else            line1_d[8*(COLS-1-int'(sweep_col)) +: 8] = BLANK;
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == SWEEP_LAST) busy_d = 1'b0;
    end

    if (rx_valid) begin
      bo_d  = rx_byte;
      brs_d = rx_rs;
      bv_d  = 1'b1;
      if (rx_rs) begin
        if (cursor_q[6]) line2_d[8*(COLS-1-int'(cursor_q[3:0])) +: 8] = rx_byte;
        else             line1_d[8*(COLS-1-int'(cursor_q[3:0])) +: 8] = rx_byte;
        if (inc_q) begin
          if (cursor_q[3:0] == 4'(COLS-1)) begin col_n = 4'h0; line_n = ~cursor_q[6]; end
          else col_n = cursor_q[3:0] + 4'h1;
        end else begin
          if (cursor_q[3:0] == 4'h0) begin col_n = 4'(COLS-1); line_n = ~cursor_q[6]; end
          else col_n = cursor_q[3:0] - 4'h1;
        end
        cursor_d = (line_n ? LINE2_BASE : 7'h00) | {3'b000, col_n};
      end else if (is_cmd(rx_byte, CMD_DDRAM)) begin
        if (rx_byte[5:4] != 2'b00 || int'(rx_byte[3:0]) >= COLS) begin
          bv_d  = 1'b0;
          err_d = 1'b1;
        end else begin
          cursor_d = {rx_byte[6], 2'b00, rx_byte[3:0]};
        end
      end else if (is_cmd(rx_byte, CMD_FUNC)) begin
        bv_d = 1'b1;
      end else if (is_cmd(rx_byte, CMD_DISP)) begin
        disp_d = rx_byte[2];
      end else if (is_cmd(rx_byte, CMD_ENTRY)) begin
        inc_d = rx_byte[1];
      end else if (is_cmd(rx_byte, CMD_HOME)) begin
        cursor_d = 7'h00;
      end else if (is_cmd(rx_byte, CMD_CLEAR)) begin
        busy_d   = 1'b1;
        sweep_d  = '0;
        cursor_d = 7'h00;
        inc_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line1_q  <= {COLS{BLANK}};
      line2_q  <= {COLS{BLANK}};
      cursor_q <= 7'h00;
      disp_q   <= 1'b0;
      inc_q    <= 1'b1;
      busy_q   <= 1'b0;
      sweep_q  <= '0;
      bv_q     <= 1'b0;
      err_q    <= 1'b0;
      bo_q     <= 8'h00;
      brs_q    <= 1'b0;
    end else begin
      line1_q  <= line1_d;
      line2_q  <= line2_d;
      cursor_q <= cursor_d;
      disp_q   <= disp_d;
      inc_q    <= inc_d;
      busy_q   <= busy_d;
      sweep_q  <= sweep_d;
      bv_q     <= bv_d;
      err_q    <= err_d;
      bo_q     <= bo_d;
      brs_q    <= brs_d;
    end
  end

  assign first_line  = line1_q;
  assign second_line = line2_q;
  assign display_on  = disp_q;
  assign cursor      = cursor_q;
  assign busy        = busy_q;
  assign byte_valid  = bv_q;
  assign byte_out    = bo_q;
  assign byte_rs     = brs_q;
  assign err         = err_q;

endmodule
